// File: rtl/sha512_arb_if.sv
// Requester, engine-control and FIFO signal bundle for sha512_arb.
// SHA512_ARB_ABORT_EN adds the per-requester abort line.
interface sha512_arb_if #(
   parameter int NumReq = 2
);
   logic [NumReq-1:0]       req_start_i;
   logic [NumReq-1:0]       req_grant_o;
   logic [NumReq-1:0]       req_wvalid_i;
   logic [NumReq-1:0][63:0] req_wdata_i;
   logic [NumReq-1:0][7:0]  req_wmask_i;
   logic [NumReq-1:0]       req_wlast_i;
   logic [NumReq-1:0]       req_wready_o;
   logic [NumReq-1:0]       req_done_o;
`ifdef SHA512_ARB_ABORT_EN
   logic [NumReq-1:0]       req_abort_i;
`endif
   logic                    sha_en_o;
   logic                    hash_start_o;
   logic                    hash_process_o;
   logic                    hash_done_i;
   logic                    fifo_wvalid_o;
   logic [63:0]             fifo_wdata_o;
   logic [7:0]              fifo_wmask_o;
   logic                    fifo_wready_i;
   logic [127:0]            message_length_o;

   modport slave (
`ifdef SHA512_ARB_ABORT_EN
      input  req_abort_i,
`endif
      input  req_start_i, req_wvalid_i, req_wdata_i, req_wmask_i, req_wlast_i,
      input  hash_done_i, fifo_wready_i,
      output req_grant_o, req_wready_o, req_done_o, sha_en_o, hash_start_o,
      output hash_process_o, fifo_wvalid_o, fifo_wdata_o, fifo_wmask_o, message_length_o
   );

   modport master (
`ifdef SHA512_ARB_ABORT_EN
      output req_abort_i,
`endif
      output req_start_i, req_wvalid_i, req_wdata_i, req_wmask_i, req_wlast_i,
      output hash_done_i, fifo_wready_i,
      input  req_grant_o, req_wready_o, req_done_o, sha_en_o, hash_start_o,
      input  hash_process_o, fifo_wvalid_o, fifo_wdata_o, fifo_wmask_o, message_length_o
   );
endinterface

// File: rtl/sha512_arb.sv
// Round-robin session arbiter and sequencer sharing one SHA-512 engine between two requesters.
// Optional feature macro: SHA512_ARB_ABORT_EN (owner may abort a running session).
module sha512_arb #(
   parameter int NumReq = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   sha512_arb_if.slave bus
);

`ifdef SHA512_ARB_ABORT_EN
   typedef enum logic [2:0] {
      Idle     = 3'd0,
      Start    = 3'd1,
      Stream   = 3'd2,
      Process  = 3'd3,
      WaitDone = 3'd4,
      Done     = 3'd5,
      Abort    = 3'd6
   } state_e;
   localparam state_e AbortSt = Abort;
`else
   typedef enum logic [2:0] {
      Idle     = 3'd0,
      Start    = 3'd1,
      Stream   = 3'd2,
      Process  = 3'd3,
      WaitDone = 3'd4,
      Done     = 3'd5
   } state_e;
   // Without the abort feature abort_s is tied low, so this target is never taken.
   localparam state_e AbortSt = Idle;
`endif

   function automatic logic [3:0] popcount8(input logic [7:0] mask);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'd0, mask[i]};
      end
      return cnt;
   endfunction

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   state_e          state_r, state_s;
   logic            owner_r, owner_s;
   logic            last_owner_r, last_owner_s;
   logic [127:0]    length_r;
   logic [1:0]      grant_r, grant_s;
   logic [1:0]      done_r, done_s;
   logic            sha_en_r, sha_en_s;
   logic            hash_start_r, hash_start_s;
   logic            hash_process_r, hash_process_s;
   logic            clear_len_s, accept_s, stream_s, abort_s;
   logic            fifo_wvalid_s, wready_own_s;
   logic            own_wvalid_s, own_wlast_s;
   logic [63:0]     own_wdata_s;
   logic [7:0]      own_wmask_s;

   assign own_wvalid_s = bus.req_wvalid_i[owner_r];
   assign own_wlast_s  = bus.req_wlast_i[owner_r];
   assign own_wdata_s  = bus.req_wdata_i[owner_r];
   assign own_wmask_s  = bus.req_wmask_i[owner_r];
`ifdef SHA512_ARB_ABORT_EN
   assign abort_s      = bus.req_abort_i[owner_r];
`else
   assign abort_s      = 1'b0;
`endif

   // Next-state, arbitration and the combinational stream handshake.
   always_comb begin
      state_s       = state_r;
      owner_s       = owner_r;
      last_owner_s  = last_owner_r;
      clear_len_s   = 1'b0;
      accept_s      = 1'b0;
      stream_s      = 1'b0;
      fifo_wvalid_s = 1'b0;
      wready_own_s  = 1'b0;
      case (state_r)
         Idle: begin
            if (bus.req_start_i != 2'b00) begin
               clear_len_s = 1'b1;
               state_s     = Start;
               if (bus.req_start_i == 2'b11) begin
                  owner_s = ~last_owner_r;
               end else begin
                  owner_s = bus.req_start_i[1];
               end
            end else begin
               state_s = Idle;
            end
         end
         Start: begin
            if (abort_s) begin
               state_s = AbortSt;
            end else begin
               state_s = Stream;
            end
         end
         Stream: begin
            if (abort_s) begin
               state_s = AbortSt;
            end else begin
               stream_s = 1'b1;
               // An empty final word is swallowed here rather than written to the FIFO.
               if (own_wvalid_s && own_wlast_s && (own_wmask_s == 8'h00)) begin
                  wready_own_s = 1'b1;
                  accept_s     = 1'b1;
               end else begin
                  fifo_wvalid_s = own_wvalid_s;
                  wready_own_s  = bus.fifo_wready_i;
                  accept_s      = own_wvalid_s && bus.fifo_wready_i;
               end
               if (accept_s && own_wlast_s) begin
                  state_s = Process;
               end else begin
                  state_s = Stream;
               end
            end
         end
         Process: begin
            if (abort_s) begin
               state_s = AbortSt;
            end else begin
               state_s = WaitDone;
            end
         end
         WaitDone: begin
            if (abort_s) begin
               state_s = AbortSt;
            end else if (bus.hash_done_i) begin
               state_s = Done;
            end else begin
               state_s = WaitDone;
            end
         end
         Done: begin
            last_owner_s = owner_r;
            state_s      = Idle;
         end
`ifdef SHA512_ARB_ABORT_EN
         Abort: begin
            last_owner_s = owner_r;
            state_s      = Idle;
         end
`endif
         default: begin
            state_s = Idle;
         end
      endcase
   end

   // Control outputs decoded from the next state so they can be registered.
   always_comb begin
      sha_en_s       = (state_s != Idle) && (state_s != AbortSt);
      grant_s        = sha_en_s ? onehot2(owner_s) : 2'b00;
      hash_start_s   = (state_s == Start);
      hash_process_s = (state_s == Process);
      done_s         = (state_s == Done) ? onehot2(owner_s) : 2'b00;
   end

   // State, ownership, length counter and registered control outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r        <= Idle;
         owner_r        <= 1'b0;
         last_owner_r   <= 1'b1;
         length_r       <= 128'd0;
         grant_r        <= 2'b00;
         done_r         <= 2'b00;
         sha_en_r       <= 1'b0;
         hash_start_r   <= 1'b0;
         hash_process_r <= 1'b0;
      end else begin
         state_r        <= state_s;
         owner_r        <= owner_s;
         last_owner_r   <= last_owner_s;
         if (clear_len_s) begin
            length_r <= 128'd0;
         end else if (accept_s) begin
            length_r <= length_r + {121'd0, popcount8(own_wmask_s), 3'b000};
         end else begin
            length_r <= length_r;
         end
         grant_r        <= grant_s;
         done_r         <= done_s;
         sha_en_r       <= sha_en_s;
         hash_start_r   <= hash_start_s;
         hash_process_r <= hash_process_s;
      end
   end

   assign bus.req_grant_o      = grant_r;
   assign bus.req_done_o       = done_r;
   assign bus.sha_en_o         = sha_en_r;
   assign bus.hash_start_o     = hash_start_r;
   assign bus.hash_process_o   = hash_process_r;
   assign bus.fifo_wvalid_o    = fifo_wvalid_s;
   assign bus.fifo_wdata_o     = stream_s ? own_wdata_s : 64'd0;
   assign bus.fifo_wmask_o     = stream_s ? own_wmask_s : 8'h00;
   assign bus.req_wready_o     = wready_own_s ? onehot2(owner_r) : 2'b00;
   assign bus.message_length_o = length_r;

endmodule
